// File: rtl/interp_pkg.sv
// Definitions shared by the linear and circular interpolators: FSM encodings,
// direction/axis encodings and a sign-magnitude helper.
package interp_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_WORK = 3'd2;
  localparam logic [2:0] S_OVER = 3'd3;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef enum logic {
    AXIS_X = 1'b0,
    AXIS_Y = 1'b1
  } axis_e;

  // Callers sign-extend narrower coordinates into this width before use.
  localparam int ABS_W = 64;

  function automatic logic [ABS_W-1:0] abs_signed(input logic signed [ABS_W-1:0] v);
    return v[ABS_W-1] ? unsigned'(-v) : unsigned'(v);
  endfunction

endpackage

// File: rtl/step_rate_div.sv
// Feed-rate pacing counter: one tick every div+1 enabled, non-held cycles.
module step_rate_div #(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && !hold && (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !hold) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/line_interp_pbp.sv
// Point-by-point linear interpolator: paces steps with feed_div and chooses the
// axis of each step from the sign of the deviation accumulator F.
module line_interp_pbp
  import interp_pkg::*;
#(
  parameter int W     = 16,
  parameter int DIV_W = 12
) (
  input  logic                pulse_clk,
  input  logic                sys_rst_l,
  input  logic                start,
  input  logic                abort,
  input  logic                hold,
  input  logic signed [W-1:0] Xe,
  input  logic signed [W-1:0] Ye,
  input  logic [DIV_W-1:0]    feed_div,
  output logic                step_x,
  output logic                step_y,
  output logic                dir_x,
  output logic                dir_y,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [W:0]          steps_left
);

  logic [2:0]              state;
  logic [W-1:0]            xa;
  logic [W-1:0]            ya;
  logic [DIV_W-1:0]        feed_div_q;
  logic signed [W+1:0]     f_acc;
  logic                    tick;
  logic                    tick_en;
  logic                    tick_clr;
  axis_e                   step_axis;
  logic signed [ABS_W-1:0] xe_ext;
  logic signed [ABS_W-1:0] ye_ext;

  assign xe_ext = ABS_W'(Xe);
  assign ye_ext = ABS_W'(Ye);

  assign busy = (state != S_IDLE);
  assign done = (state == S_OVER);

  // Pacing runs only while steps remain; abort freezes it so no step escapes.
  assign tick_clr = (state != S_WORK);
  assign tick_en  = (state == S_WORK) && (steps_left != '0) && !abort;

  // With Xa==0 F stays 0, so the Y-only move must be forced explicitly.
  assign step_axis = ((xa == '0) || f_acc[W+1]) ? AXIS_Y : AXIS_X;

  step_rate_div #(
    .DIV_W(DIV_W)
  ) u_rate (
    .clk  (pulse_clk),
    .rst_n(sys_rst_l),
    .clr  (tick_clr),
    .en   (tick_en),
    .hold (hold),
    .div  (feed_div_q),
    .tick (tick)
  );

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state      <= S_IDLE;
      xa         <= '0;
      ya         <= '0;
      feed_div_q <= '0;
      f_acc      <= '0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      step_x     <= 1'b0;
      step_y     <= 1'b0;
      aborted    <= 1'b0;
      steps_left <= '0;
    end else begin
      step_x <= 1'b0;
      step_y <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_INIT;
            xa         <= W'(abs_signed(xe_ext));
            ya         <= W'(abs_signed(ye_ext));
            dir_x      <= Xe[W-1] ? DIR_NEG : DIR_POS;
            dir_y      <= Ye[W-1] ? DIR_NEG : DIR_POS;
            feed_div_q <= feed_div;
            f_acc      <= '0;
          end
        end
        S_INIT: begin
          steps_left <= {1'b0, xa} + {1'b0, ya};
          if (abort || ((xa == '0) && (ya == '0))) begin
            state   <= S_OVER;
            aborted <= abort;
          end else begin
            state <= S_WORK;
          end
        end
        S_WORK: begin
          if (abort) begin
            state   <= S_OVER;
            aborted <= 1'b1;
          end else if (steps_left == '0) begin
            state <= S_OVER;
          end else if (tick) begin
            steps_left <= steps_left - (W+1)'(1);
            if (step_axis == AXIS_X) begin
              step_x <= 1'b1;
              f_acc  <= f_acc - $signed({2'b00, ya});
            end else begin
              step_y <= 1'b1;
              if (xa != '0) f_acc <= f_acc + $signed({2'b00, xa});
            end
          end
        end
        S_OVER: begin
          state   <= S_IDLE;
          aborted <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_interp_pbp.sv
// Randomised bench for line_interp_pbp (W=8) against a path-list reference
// model, plus literal checks on the documented example moves.
module tb_line_interp_pbp;

  localparam int W     = 8;
  localparam int DIV_W = 12;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                hold  = 1'b0;
  logic signed [W-1:0] xe_in = '0;
  logic signed [W-1:0] ye_in = '0;
  logic [DIV_W-1:0]    fd_in = '0;

  logic       step_x, step_y, dir_x, dir_y, busy, done, aborted;
  logic [W:0] steps_left;

  line_interp_pbp #(
    .W(W),
    .DIV_W(DIV_W)
  ) dut (
    .pulse_clk (clk),
    .sys_rst_l (rst_n),
    .start     (start),
    .abort     (abort),
    .hold      (hold),
    .Xe        (xe_in),
    .Ye        (ye_in),
    .feed_div  (fd_in),
    .step_x    (step_x),
    .step_y    (step_y),
    .dir_x     (dir_x),
    .dir_y     (dir_y),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- reference model ----------------
  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Whole move as a string of axis letters, plus the final F value.
  function automatic void model_path(input int xa, input int ya, output string s, output int f);
    s = "";
    f = 0;
    for (int i = 0; i < xa + ya; i++) begin
      if (xa != 0 && f >= 0) begin
        s = {s, "X"};
        f = f - ya;
      end else begin
        s = {s, "Y"};
        if (xa != 0) f = f + xa;
      end
    end
  endfunction

  bit    m_busy = 0, m_over = 0;
  int    m_age = 0, m_pace = 0, m_fd = 0, m_idx = 0, m_f = 0;
  string m_path = "";
  logic  e_sx = 0, e_sy = 0, e_dx = 0, e_dy = 0, e_done = 0, e_abt = 0;
  int    e_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_over = 0; m_age = 0; m_pace = 0; m_idx = 0; m_path = "";
      e_sx = 0; e_sy = 0; e_dx = 0; e_dy = 0; e_done = 0; e_abt = 0; e_left = 0;
    end else begin
      e_sx = 0; e_sy = 0; e_done = 0; e_abt = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_age = 0; m_idx = 0; m_fd = int'(fd_in);
          model_path(iabs(int'(xe_in)), iabs(int'(ye_in)), m_path, m_f);
          e_dx = (xe_in < 0);
          e_dy = (ye_in < 0);
        end
      end else begin
        m_age++;
        if (m_over) begin
          m_busy = 0;
          m_over = 0;
        end else if (m_age == 1) begin
          e_left = m_path.len();
          m_pace = 0;
          if (abort || e_left == 0) begin
            m_over = 1;
            e_abt  = abort;
          end
        end else if (abort) begin
          m_over = 1;
          e_abt  = 1;
        end else if (m_idx == m_path.len()) begin
          m_over = 1;
        end else if (!hold) begin
          // a step is due on every (feed_div+1)-th unheld working cycle
          if (m_pace == m_fd) begin
            if (m_path.getc(m_idx) == "X") e_sx = 1;
            else e_sy = 1;
            m_idx++;
            e_left--;
            m_pace = 0;
          end else begin
            m_pace++;
          end
        end
        e_done = m_over;
      end
    end
  end

  // ---------------- checking ----------------
  int    n_vec = 0, n_bad = 0;
  int    start_edge = -100;
  string mon_str = "";
  int    mon_nx = 0, mon_ny = 0, mon_first = -1, mon_done_off = -1, mon_done_left = -1;
  int    mon_hp = 0, mon_init_left = -1;
  logic  mon_done_abt = 0, mon_dirx = 0, mon_diry = 0;

  task automatic check_eq(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_str(input string name, input string got, input string exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, got, exp);
    end
  endtask

  task automatic check_cycle();
    logic [15:0] got, exp;
    got = {step_x, step_y, dir_x, dir_y, busy, done, aborted, steps_left};
    exp = {e_sx, e_sy, e_dx, e_dy, m_busy, e_done, e_abt, 9'(e_left)};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL outputs@%0d: got sx%b sy%b dx%b dy%b busy%b done%b abt%b left%0d, expected sx%b sy%b dx%b dy%b busy%b done%b abt%b left%0d",
               cyc_n, got[15], got[14], got[13], got[12], got[11], got[10], got[9], got[8:0],
               exp[15], exp[14], exp[13], exp[12], exp[11], exp[10], exp[9], exp[8:0]);
    end
    if (cyc_n == start_edge) begin
      mon_str = ""; mon_nx = 0; mon_ny = 0; mon_first = -1; mon_done_off = -1;
      mon_done_left = -1; mon_done_abt = 0; mon_hp = 0; mon_init_left = -1;
    end
    if (cyc_n - start_edge == 1) mon_init_left = int'(steps_left);
    if (step_x || step_y) begin
      if (mon_first < 0) mon_first = cyc_n - start_edge;
      if (hold) mon_hp++;
    end
    if (step_x) begin mon_nx++; mon_str = {mon_str, "X"}; end
    if (step_y) begin mon_ny++; mon_str = {mon_str, "Y"}; end
    if (done && mon_done_off < 0) begin
      mon_done_off  = cyc_n - start_edge;
      mon_done_left = int'(steps_left);
      mon_done_abt  = aborted;
      mon_dirx      = dir_x;
      mon_diry      = dir_y;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
  endtask

  // hmode: 0 no hold, 1 hold window [h0,h0+hlen), 2 random hold.
  task automatic run_move(input int xe, input int ye, input int fd, input int hmode,
                          input int h0, input int hlen, input int abort_after, input bit poke);
    int off;
    bit fin;
    xe_in = W'(xe); ye_in = W'(ye); fd_in = DIV_W'(fd);
    start = 1'b1;
    start_edge = cyc_n + 1;
    fin = 0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      tick();
      xe_in = W'($urandom); ye_in = W'($urandom); fd_in = DIV_W'($urandom);
      off = cyc_n - start_edge;
      fin = (mon_done_off >= 0);
      abort = !fin && (abort_after >= 0) && (mon_nx + mon_ny >= abort_after);
      case (hmode)
        1: hold = (off >= h0) && (off < h0 + hlen);
        2: hold = ($urandom_range(0, 3) == 0);
        default: hold = 1'b0;
      endcase
      start = poke && (off == 20);
    end
    if (!fin) begin
      n_vec++;
      n_bad++;
      $display("FAIL move_timeout xe=%0d ye=%0d: got no done, expected done", xe, ye);
    end
    abort = 1'b0; hold = 1'b0; start = 1'b0;
    tick();
  endtask

  initial begin
    string s;
    int    f;
    int    xe, ye, fd, aa;
    bit    pk;

    // model pinned to the hand-worked 5/3 path
    model_path(5, 3, s, f);
    check_str("model_path_5_3", s, "XYXYXXYX");
    check_eq("model_f_end_5_3", f, 0);

    repeat (3) tick();
    check_eq("reset_busy", busy, 0);
    check_eq("reset_steps_left", steps_left, 0);
    check_eq("reset_steps", {step_x, step_y, done, aborted}, 0);
    rst_n = 1'b1;
    tick();

    run_move(5, 3, 0, 0, 0, 0, -1, 0);
    check_str("path_5_3", mon_str, "XYXYXXYX");
    check_eq("first_step_5_3", mon_first, 2);
    check_eq("done_off_5_3", mon_done_off, 10);

    run_move(-4, 0, 2, 0, 0, 0, -1, 0);
    check_eq("nx_m4_0", mon_nx, 4);
    check_eq("ny_m4_0", mon_ny, 0);
    check_eq("first_step_m4_0", mon_first, 4);
    check_eq("done_off_m4_0", mon_done_off, 14);
    check_eq("dir_x_m4_0", mon_dirx, 1);

    run_move(0, -3, 0, 0, 0, 0, -1, 0);
    check_eq("nx_0_m3", mon_nx, 0);
    check_eq("ny_0_m3", mon_ny, 3);
    check_eq("dir_y_0_m3", mon_diry, 1);

    run_move(0, 0, 0, 0, 0, 0, -1, 0);
    check_eq("done_off_0_0", mon_done_off, 1);
    check_eq("steps_0_0", mon_nx + mon_ny, 0);

    run_move(100, 100, 0, 0, 0, 0, 10, 0);
    check_eq("abort_steps_left", mon_done_left, 190);
    check_eq("abort_flag", mon_done_abt, 1);
    check_eq("abort_steps_taken", mon_nx + mon_ny, 10);

    run_move(6, 2, 1, 1, 6, 10, -1, 0);
    check_eq("nx_hold", mon_nx, 6);
    check_eq("ny_hold", mon_ny, 2);
    check_eq("pulses_during_hold", mon_hp, 0);

    run_move(-128, 127, 0, 0, 0, 0, -1, 1);
    check_eq("init_left_m128", mon_init_left, 255);
    check_eq("nx_m128", mon_nx, 128);
    check_eq("ny_m128", mon_ny, 127);
    check_eq("abt_m128", mon_done_abt, 0);

    // asynchronous reset in the middle of a move
    xe_in = 8'sd50; ye_in = 8'sd30; fd_in = '0;
    start = 1'b1;
    start_edge = cyc_n + 1;
    repeat (20) begin
      tick();
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check_cycle();
    check_eq("async_reset_outputs",
             {step_x, step_y, dir_x, dir_y, busy, done, aborted, steps_left}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_move(7, -5, 1, 0, 0, 0, -1, 0);
    check_eq("nx_after_reset", mon_nx, 7);
    check_eq("ny_after_reset", mon_ny, 5);

    for (int m = 0; m < 40; m++) begin
      if ($urandom_range(0, 7) == 0) begin
        xe = int'($urandom_range(0, 255)) - 128;
        ye = int'($urandom_range(0, 255)) - 128;
      end else begin
        xe = int'($urandom_range(0, 40)) - 20;
        ye = int'($urandom_range(0, 40)) - 20;
      end
      fd = int'($urandom_range(0, 3));
      aa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, iabs(xe) + iabs(ye))) : -1;
      pk = 1'($urandom_range(0, 1));
      run_move(xe, ye, fd, 2, 0, 0, aa, pk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no summary by time limit, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
